// File: rtl/dshot_pkg.sv
// Shared DShot definitions: frame geometry, throttle limits, receiver state
// encoding and the 4-bit frame checksum.
package dshot_pkg;

  localparam int DSHOT_FRAME_BITS = 16;
  localparam int DSHOT_THR_MIN    = 48;
  localparam int DSHOT_THR_W      = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HIGH     = 2'd1,
    LOW      = 2'd2,
    WAIT_GAP = 2'd3
  } dshot_state_e;

  // Nibble-wise XOR of the 12-bit payload (throttle + telemetry bit).
  function automatic logic [3:0] dshot_crc(input logic [11:0] payload);
    return payload[3:0] ^ payload[7:4] ^ payload[11:8];
  endfunction

endpackage

// File: rtl/dshot_rx_channel.sv
// Single-pin DShot receiver: synchroniser, bit-timing FSM, checksum,
// throttle scaling and failsafe timeout for one channel.
module dshot_rx_channel
  import dshot_pkg::*;
#(
  parameter int CLK_HZ      = 16000000,
  parameter int DSHOT_RATE  = 150000,
  parameter int OUT_W       = 8,
  parameter int TIMEOUT_CYC = 320000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [OUT_W-1:0] speed,
  output logic             frame_valid,
  output logic             frame_err,
  output logic             link_ok,
  output logic             telem_req
);

  localparam int BIT_CYC = CLK_HZ / DSHOT_RATE;
  localparam int THRESH  = BIT_CYC / 2;
  localparam int GAP     = 2 * BIT_CYC;
  localparam int CNT_W   = $clog2(GAP + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int SHIFT   = DSHOT_THR_W - OUT_W;

  logic                   sync1_r, sync2_r, level_r, rise_r, fall_r;
  dshot_state_e           state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [4:0]             bitcnt_r, bitcnt_s;
  logic [14:0]            shift_r, shift_s;
  logic                   bit_s, eval_s, err_s;
  logic [15:0]            frame_s;
  logic [DSHOT_THR_W-1:0] thr_s;
  logic                   crc_ok_s, valid_s, bad_s;
  logic [OUT_W-1:0]       speed_s, speed_r;
  logic [TO_W-1:0]        to_r;
  logic                   frame_valid_r, frame_err_r, link_ok_r, telem_r;

  // Two-flop synchroniser followed by a registered edge detector;
  // level_r is the line level aligned with rise_r/fall_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      level_r <= sync2_r;
      rise_r  <= sync2_r & ~level_r;
      fall_r  <= ~sync2_r & level_r;
    end
  end

  // Bit-timing FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      bitcnt_r <= 5'd0;
      shift_r  <= 15'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bitcnt_r <= bitcnt_s;
      shift_r  <= shift_s;
    end
  end

  // Next-state logic; one shared counter times high pulses, low gaps and the inter-frame gap.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    bitcnt_s = bitcnt_r;
    shift_s  = shift_r;
    eval_s   = 1'b0;
    err_s    = 1'b0;
    bit_s    = (cnt_r >= CNT_W'(THRESH));
    case (state_r)
      IDLE: begin
        if (rise_r) begin
          state_s  = HIGH;
          cnt_s    = {CNT_W{1'b0}};
          bitcnt_s = 5'd0;
        end else begin
          state_s = IDLE;
        end
      end
      HIGH: begin
        if (fall_r) begin
          shift_s  = {shift_r[13:0], bit_s};
          bitcnt_s = bitcnt_r + 5'd1;
          cnt_s    = {CNT_W{1'b0}};
          if (bitcnt_r == 5'(DSHOT_FRAME_BITS - 1)) begin
            eval_s  = 1'b1;
            state_s = WAIT_GAP;
          end else begin
            state_s = LOW;
          end
        end else if (cnt_r >= CNT_W'(BIT_CYC - 1)) begin
          err_s   = 1'b1;
          state_s = WAIT_GAP;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      LOW: begin
        if (rise_r) begin
          state_s = HIGH;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r >= CNT_W'(GAP - 1)) begin
          err_s   = (bitcnt_r != 5'd0);
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      WAIT_GAP: begin
        if (rise_r || level_r) begin
          cnt_s = {CNT_W{1'b0}};
        end else if (cnt_r >= CNT_W'(GAP - 1)) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Frame check and throttle scaling on the frame completed by the current bit.
  always_comb begin
    frame_s  = {shift_r, bit_s};
    thr_s    = frame_s[15:5];
    crc_ok_s = (frame_s[3:0] == dshot_crc(frame_s[15:4]));
    valid_s  = eval_s & crc_ok_s;
    bad_s    = err_s | (eval_s & ~crc_ok_s);
    if (thr_s < DSHOT_THR_W'(DSHOT_THR_MIN)) begin
      speed_s = {OUT_W{1'b0}};
    end else begin
      speed_s = OUT_W'((thr_s - DSHOT_THR_W'(DSHOT_THR_MIN)) >> SHIFT);
    end
  end

  // Output registers and saturating failsafe counter; a valid frame beats the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      link_ok_r     <= 1'b0;
      telem_r       <= 1'b0;
      speed_r       <= {OUT_W{1'b0}};
      to_r          <= {TO_W{1'b0}};
    end else begin
      frame_valid_r <= valid_s;
      frame_err_r   <= bad_s;
      if (valid_s) begin
        to_r      <= {TO_W{1'b0}};
        link_ok_r <= 1'b1;
        telem_r   <= frame_s[4];
        speed_r   <= speed_s;
      end else if (to_r == TO_W'(TIMEOUT_CYC - 1)) begin
        to_r      <= TO_W'(TIMEOUT_CYC);
        link_ok_r <= 1'b0;
        telem_r   <= 1'b0;
        speed_r   <= {OUT_W{1'b0}};
      end else if (to_r != TO_W'(TIMEOUT_CYC)) begin
        to_r <= to_r + TO_W'(1);
      end else begin
        to_r <= to_r;
      end
    end
  end

  assign speed       = speed_r;
  assign frame_valid = frame_valid_r;
  assign frame_err   = frame_err_r;
  assign link_ok     = link_ok_r;
  assign telem_req   = telem_r;

endmodule

// File: rtl/dshot_rx_bank.sv
// Bank of independent DShot receivers sharing a reset synchroniser; speeds
// are packed onto one flat bus, channel i at [i*OUT_W +: OUT_W].
module dshot_rx_bank
  import dshot_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CLK_HZ      = 16000000,
  parameter int DSHOT_RATE  = 150000,
  parameter int OUT_W       = 8,
  parameter int TIMEOUT_CYC = 320000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       dshot_in,
  output logic [NUM_CH*OUT_W-1:0] speed_flat,
  output logic [NUM_CH-1:0]       frame_valid,
  output logic [NUM_CH-1:0]       frame_err,
  output logic [NUM_CH-1:0]       link_ok,
  output logic [NUM_CH-1:0]       telem_req
);

  logic rst_meta_r, rst_sync_r;

  // Reset asserts immediately, releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_r <= 1'b0;
      rst_sync_r <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_sync_r <= rst_meta_r;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dshot_rx_channel #(
      .CLK_HZ     (CLK_HZ),
      .DSHOT_RATE (DSHOT_RATE),
      .OUT_W      (OUT_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_sync_r),
      .din        (dshot_in[i]),
      .speed      (speed_flat[i*OUT_W +: OUT_W]),
      .frame_valid(frame_valid[i]),
      .frame_err  (frame_err[i]),
      .link_ok    (link_ok[i]),
      .telem_req  (telem_req[i])
    );
  end

endmodule

// File: doc/dshot_rx_bank.md
Name: dshot_rx_bank

Overview:
- Parametrised multi-channel DShot receiver. Successor to the per-pin speed handlers.
- Decodes NUM_CH independent DShot input pins and checks the 4-bit CRC on each frame.
- Scales throttle to OUT_W-bit speeds and packs them into one flat bus for the PWM and BL-Ctrl I2C blocks.
- Adds per-channel failsafe timeout, error flags and telemetry-request capture.

Parameters:
- NUM_CH, 8, number of DShot input channels.
- CLK_HZ, 16000000, clk frequency in Hz.
- DSHOT_RATE, 150000, DShot bit rate in bit/s.
- OUT_W, 8, output speed width per channel; legal range 1..11.
- TIMEOUT_CYC, 320000, cycles without a valid frame before failsafe (20 ms at 16 MHz).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- dshot_in  input  NUM_CH  raw DShot pins, asynchronous to clk.
- speed_flat  output  NUM_CH*OUT_W  channel i at [i*OUT_W +: OUT_W].
- frame_valid  output  NUM_CH  1-cycle pulse per accepted frame.
- frame_err  output  NUM_CH  1-cycle pulse per CRC, framing or runt error.
- link_ok  output  NUM_CH  high while a valid frame was seen within TIMEOUT_CYC.
- telem_req  output  NUM_CH  telemetry bit of the last valid frame.

Behaviour:
- Reset: async assert on rst_n low, release synchronised. All outputs are 0; all counters, shift registers and sync FFs are cleared. Reset mid-frame discards the partial frame, with no pulses.
- Constants: BIT_CYC = CLK_HZ/DSHOT_RATE (106); THRESH = BIT_CYC/2; GAP = 2*BIT_CYC.
- Input path per channel: 2-FF synchroniser, then registered edge detect.
- Channel FSM, IDLE:
  - Rising edge -> HIGH, clear the high counter.
- Channel FSM, HIGH:
  - Count cycles while high.
  - Falling edge: shift in bit = (count >= THRESH); bitcnt += 1; go to LOW, clear the low counter.
  - count reaches BIT_CYC (stuck high): frame_err, go to WAIT_GAP.
- Channel FSM, LOW:
  - Rising edge with bitcnt < 16 -> HIGH.
  - bitcnt == 16 -> evaluate the frame on the same cycle the 16th falling edge is registered, then go to WAIT_GAP.
  - Low count reaches GAP with 0 < bitcnt < 16: runt frame, frame_err, go to IDLE.
- Channel FSM, WAIT_GAP:
  - Line must stay low for GAP cycles -> IDLE.
  - Any rising edge restarts the gap count. Extra bits beyond 16 are ignored with no error.
- Frame f[15:0] layout: throttle = f[15:5], telem = f[4], crc = f[3:0].
- CRC check: crc must equal (f[15:4] ^ f[15:8] ^ f[15:12]) & 4'hF.
- CRC fail: frame_err pulse. speed, telem_req, link_ok and the timeout counter are unchanged.
- CRC pass:
  - frame_valid pulse; telem_req <= telem; timeout counter <= 0; link_ok <= 1.
  - throttle < 48 (disarm or command): speed <= 0.
  - Otherwise speed <= (throttle-48) >> (11-OUT_W), computed at 11-bit width, truncated to OUT_W. For OUT_W=8 the range is 0..249.
- Latency: frame_valid, frame_err and speed update appear together, 4 clk after the pin's 16th falling edge (2 sync + edge reg + eval reg).
- Timeout counter:
  - Saturating; increments every cycle and is cleared only by a valid frame.
  - Reaching TIMEOUT_CYC: link_ok <= 0 and speed <= 0 on the same cycle; telem_req <= 0.
  - A valid frame on the same cycle wins.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

Decomposition:
- Shared package dshot_pkg:
  - DSHOT_FRAME_BITS = 16, DSHOT_THR_MIN = 48, DSHOT_THR_W = 11.
  - Channel-state enum: IDLE, HIGH, LOW, WAIT_GAP.
  - dshot_crc function.
- Sub-module dshot_rx_channel (one pin, one speed):
  - Contains synchroniser, FSM, CRC, scaling and timeout.
  - Instantiated NUM_CH times by a generate loop in dshot_rx_bank.

Test Plan:
- Valid frame: ch0 sends 0x830B (throttle 1048, telem 0) at 150 kbit/s -> frame_valid[0] pulses once 4 clk after the 16th falling edge; speed ch0 = 125; link_ok[0] = 1; other channels stay 0.
- Full scale: ch3 sends 0xFFEE -> speed ch3 = 249. Then 0x0000 -> speed 0 and frame_valid pulses (disarm is a valid frame).
- CRC error: after 0x830B, send 0x830A -> frame_err pulses; speed stays 125; link_ok stays 1.
- Runt: 9 bits then low for more than GAP -> one frame_err pulse, no frame_valid. The next good frame is accepted.
- Failsafe (TIMEOUT_CYC=2000): valid 0x830B, then silence -> link_ok and speed drop to 0 exactly 2000 cycles after frame_valid. A new valid frame restores them.
- Reset and concurrency: assert rst_n mid-frame on ch1 -> outputs are 0 immediately. After release, a frame starting mid-stream yields no false frame_valid. Simultaneous valid frames on all 8 channels -> all frame_valid bits pulse in the same cycle.
